// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC multiplexed-bus block: bus states,
// default phase length and the RTC register map used by the sequencers.
package rtc_pkg;

  // clk cycles per bus phase (100 ns at 100 MHz)
  localparam int PHASE_CYC_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_SET,
    S_A_STB,
    S_A_HOLD,
    S_D_SET,
    S_D_STB,
    S_D_HOLD,
    S_RECOV
  } bus_state_t;

  // RTC register addresses issued by the init / read sequencers
  localparam logic [7:0] RTC_REG_CTRL  = 8'h00;
  localparam logic [7:0] RTC_REG_STAT  = 8'h01;
  localparam logic [7:0] RTC_REG_SEC   = 8'h02;
  localparam logic [7:0] RTC_REG_MIN   = 8'h03;
  localparam logic [7:0] RTC_REG_HOUR  = 8'h04;
  localparam logic [7:0] RTC_REG_DAY   = 8'h05;
  localparam logic [7:0] RTC_REG_MON   = 8'h06;
  localparam logic [7:0] RTC_REG_YEAR  = 8'h07;
  localparam logic [7:0] RTC_REG_RAM0  = 8'h20;

  // Fixed bus-cycle order; RECOV wraps back to IDLE
  function automatic bus_state_t next_state(input bus_state_t s);
    case (s)
      S_IDLE:   next_state = S_A_SET;
      S_A_SET:  next_state = S_A_STB;
      S_A_STB:  next_state = S_A_HOLD;
      S_A_HOLD: next_state = S_D_SET;
      S_D_SET:  next_state = S_D_STB;
      S_D_STB:  next_state = S_D_HOLD;
      S_D_HOLD: next_state = S_RECOV;
      default:  next_state = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer: counts cycles within a bus state, restarts at every state
// change and stays parked at zero while the bus is idle.
module rtc_phase_timer #(
  parameter int PHASE_CYC = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic last_o
);

  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = run_i && (cnt_q == LAST_CNT);

  // Clear when idle or when the current phase ends, otherwise count up
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || last_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle generator for the RTC multiplexed AD port. Turns one read or
// write request into an address phase and a data phase, each made of
// setup / strobe / hold sub-phases of PHASE_CYC cycles, then a recovery
// phase. All bus outputs come straight from flops, computed from the
// next state, so strobes are glitch-free and aligned to state entry.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC = PHASE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] dir,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  bus_state_t state_q, state_d;
  logic       accept, last;
  logic       op_wr_q, op_wr_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;

  logic       cs_n_q, cs_n_d, ad_n_q, ad_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic       ad_oe_q, ad_oe_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] ad_out_q, ad_out_d, rdata_q, rdata_d;

  rtc_phase_timer #(
    .PHASE_CYC(PHASE_CYC)
  ) u_timer (
    .clk_i (clk),
    .rst_i (reset),
    .run_i (state_q != S_IDLE),
    .last_o(last)
  );

  // Next state: accept only in IDLE, otherwise advance at end of each phase
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (state_q == S_IDLE) begin
      if (req_wr || req_rd) begin
        accept  = 1'b1;
        state_d = S_A_SET;
      end
    end else if (last) begin
      state_d = next_state(state_q);
    end
  end

  // Transaction latch values; a write wins when both requests are high
  always_comb begin
    op_wr_d = accept ? req_wr : op_wr_q;
    addr_d  = accept ? dir    : addr_q;
    wdata_d = accept ? wdata  : wdata_q;
  end

  // Bus outputs decoded from the state being entered
  always_comb begin
    cs_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out_q;
    case (state_d)
      S_A_SET, S_A_STB, S_A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != S_A_STB);
      end
      S_D_SET, S_D_STB, S_D_HOLD: begin
        cs_n_d  = 1'b0;
        ad_oe_d = op_wr_d;
        if (op_wr_d) begin
          ad_out_d = wdata_d;
        end
        if (state_d == S_D_STB) begin
          wr_n_d = !op_wr_d;
          rd_n_d = op_wr_d;
        end
      end
      default: ;
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_RECOV) && last;
    rdata_d = (state_q == S_D_STB && last && !op_wr_q) ? ad_in : rdata_q;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request (meaningful only while busy, so no reset needed)
  always_ff @(posedge clk) begin
    op_wr_q <= op_wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Registered bus outputs; reset drops every strobe immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'h00;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cs_n_q   <= cs_n_d;
      ad_n_q   <= ad_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cs_n   = cs_n_q;
  assign ad_n   = ad_n_q;
  assign wr_n   = wr_n_q;
  assign rd_n   = rd_n_q;
  assign ad_oe  = ad_oe_q;
  assign ad_out = ad_out_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Testbench for rtc_bus_ctrl: table of directed transactions checked
// cycle by cycle against a phase-index model, plus hand sequences for
// back-to-back requests, reset abort and a 2-cycle phase instance.
module tb_rtc_bus_ctrl;

  localparam int P  = 10;
  localparam int P2 = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_wr, req_rd;
  logic [7:0] dir, wdata, ad_in;
  logic [7:0] ad_out, rdata;
  logic       ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done;

  logic       r2_req_wr, r2_req_rd;
  logic [7:0] r2_dir, r2_wdata, r2_ad_in;
  logic [7:0] r2_ad_out, r2_rdata;
  logic       r2_ad_oe, r2_cs_n, r2_ad_n, r2_wr_n, r2_rd_n, r2_busy, r2_done;

  rtc_bus_ctrl #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
    .dir(dir), .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
    .rdata(rdata), .busy(busy), .done(done)
  );

  rtc_bus_ctrl #(.PHASE_CYC(P2)) dut2 (
    .clk(clk), .reset(reset), .req_wr(r2_req_wr), .req_rd(r2_req_rd),
    .dir(r2_dir), .wdata(r2_wdata), .ad_in(r2_ad_in), .ad_out(r2_ad_out),
    .ad_oe(r2_ad_oe), .cs_n(r2_cs_n), .ad_n(r2_ad_n), .wr_n(r2_wr_n),
    .rd_n(r2_rd_n), .rdata(r2_rdata), .busy(r2_busy), .done(r2_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] dir;
    logic [7:0] wdata;
    logic [7:0] adin;
    int         extra_rd;
    int         exp_wr_low;
    int         exp_rd_low;
    logic [7:0] exp_rdata;
  } txn_t;

  txn_t tbl [5];

  int checks   = 0;
  int failures = 0;
  logic [7:0] m_ad_out;
  logic [7:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge and follow it for 7*P+15 cycles
  task automatic run_txn(input int idx, input txn_t v);
    int   wr_low = 0, rd_low = 0, done_at = -1, done_cnt = 0;
    int   perr = 0, first_j = -1, busy_after = 0, s;
    logic eff_wr;
    logic e_cs, e_adn, e_wr, e_rd, e_oe, e_busy, e_done;
    logic [7:0] rdata_at_done = 8'h00;
    eff_wr = v.wr;
    req_wr = v.wr; req_rd = v.rd; dir = v.dir; wdata = v.wdata; ad_in = ~v.adin;
    @(posedge clk);
    for (int j = 0; j < 7*P + 15; j++) begin
      @(negedge clk);
      s = (j < 7*P) ? j / P : 7;
      e_cs   = !(s <= 5);
      e_adn  = !(s <= 2);
      e_wr   = !(s == 1 || (s == 4 && eff_wr));
      e_rd   = !(s == 4 && !eff_wr);
      e_oe   = (s <= 2) || (s >= 3 && s <= 5 && eff_wr);
      e_busy = (j < 7*P);
      e_done = (j == 7*P);
      if (s <= 2) m_ad_out = v.dir;
      else if (e_oe) m_ad_out = v.wdata;
      if (!eff_wr && j == 5*P) m_rdata = v.adin;
      if (cs_n !== e_cs || ad_n !== e_adn || wr_n !== e_wr || rd_n !== e_rd ||
          ad_oe !== e_oe || ad_out !== m_ad_out || busy !== e_busy ||
          done !== e_done || rdata !== m_rdata) begin
        perr++;
        if (first_j < 0) first_j = j;
      end
      wr_low += (wr_n === 1'b0) ? 1 : 0;
      rd_low += (rd_n === 1'b0) ? 1 : 0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = j;
          rdata_at_done = rdata;
        end
      end
      if (j > 7*P && busy !== 1'b0) busy_after++;
      // inputs for the following edge
      if (j == 0) begin
        req_wr = 1'b0; req_rd = 1'b0; dir = 8'hEE; wdata = 8'hEE;
      end
      if (j == v.extra_rd - 1) req_rd = 1'b1;
      if (j == v.extra_rd)     req_rd = 1'b0;
      ad_in = (j == 5*P - 1) ? v.adin : ~v.adin;
    end
    check($sformatf("txn%0d_pattern(first_bad_j=%0d)", idx, first_j), perr, 0);
    check($sformatf("txn%0d_wr_low", idx), wr_low, v.exp_wr_low);
    check($sformatf("txn%0d_rd_low", idx), rd_low, v.exp_rd_low);
    check($sformatf("txn%0d_done_at", idx), done_at, 7*P);
    check($sformatf("txn%0d_done_cnt", idx), done_cnt, 1);
    check($sformatf("txn%0d_rdata", idx), rdata_at_done, v.exp_rdata);
    check($sformatf("txn%0d_idle_after", idx), busy_after, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int errs, dcnt, bcnt, k, done_at2;
    logic got_done;
    logic [31:0] wmask, cmask, rmask;

    tbl[0] = '{1'b1, 1'b0, 8'h02, 8'h45, 8'h00, -1, 20,  0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h21, 8'h00, 8'h37, -1, 10, 10, 8'h37};
    tbl[2] = '{1'b1, 1'b0, 8'h10, 8'hA5, 8'h11, -1, 20,  0, 8'h37};
    tbl[3] = '{1'b0, 1'b1, 8'h0F, 8'h3C, 8'hC2, -1, 10, 10, 8'hC2};
    tbl[4] = '{1'b1, 1'b1, 8'h30, 8'h5A, 8'h99, 20, 20,  0, 8'hC2};

    reset = 1'b1;
    req_wr = 1'b0; req_rd = 1'b0; dir = 8'h00; wdata = 8'h00; ad_in = 8'h00;
    r2_req_wr = 1'b0; r2_req_rd = 1'b0; r2_dir = 8'h00; r2_wdata = 8'h00; r2_ad_in = 8'h00;
    m_ad_out = 8'h00; m_rdata = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_cs_n",   cs_n,   1);
    check("rst_ad_n",   ad_n,   1);
    check("rst_wr_n",   wr_n,   1);
    check("rst_rd_n",   rd_n,   1);
    check("rst_ad_oe",  ad_oe,  0);
    check("rst_ad_out", ad_out, 0);
    check("rst_rdata",  rdata,  0);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    reset = 1'b0;

    // idle for 100 cycles with no strobe activity
    errs = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || ad_n !== 1'b1 || wr_n !== 1'b1 || rd_n !== 1'b1 ||
          ad_oe !== 1'b0 || ad_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
        errs++;
    end
    check("idle_100_cycles", errs, 0);

    for (int i = 0; i < 5; i++) begin
      run_txn(i, tbl[i]);
    end

    // back-to-back: req_wr held high, next accept one cycle after done
    req_wr = 1'b1; dir = 8'h05; wdata = 8'h77;
    @(posedge clk);
    for (int j = 0; j <= 7*P + 1; j++) begin
      @(negedge clk);
      if (j == 7*P) begin
        check("b2b_done_at_70", done, 1);
        check("b2b_busy_low_at_70", busy, 0);
      end
      if (j == 7*P + 1) begin
        check("b2b_busy_again_at_71", busy, 1);
        check("b2b_done_one_cycle", done, 0);
        req_wr = 1'b0;
      end
    end
    got_done = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
    end
    check("b2b_second_done", got_done, 1);

    // reset during data strobe of a write
    req_wr = 1'b1; dir = 8'h44; wdata = 8'h99;
    @(posedge clk);
    for (int j = 0; j <= 4*P + 2; j++) begin
      @(negedge clk);
      if (j == 0) req_wr = 1'b0;
    end
    check("abort_in_dstb_wr_n", wr_n, 0);
    #2 reset = 1'b1;
    #1;
    check("abort_cs_n",  cs_n,  1);
    check("abort_wr_n",  wr_n,  1);
    check("abort_rd_n",  rd_n,  1);
    check("abort_ad_oe", ad_oe, 0);
    check("abort_busy",  busy,  0);
    @(negedge clk);
    reset = 1'b0;
    m_ad_out = 8'h00; m_rdata = 8'h00;
    dcnt = 0; bcnt = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (done !== 1'b0) dcnt++;
      if (busy !== 1'b0 || cs_n !== 1'b1) bcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_not_resumed", bcnt, 0);
    run_txn(5, '{1'b0, 1'b1, 8'h21, 8'h00, 8'h6B, -1, 10, 10, 8'h6B});

    // PHASE_CYC=2 instance: write in 14 cycles, 2-cycle strobes
    r2_req_wr = 1'b1; r2_dir = 8'h02; r2_wdata = 8'h45;
    @(posedge clk);
    wmask = '0; cmask = '0; rmask = '0; done_at2 = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0) r2_req_wr = 1'b0;
      if (r2_wr_n === 1'b0) wmask[j] = 1'b1;
      if (r2_cs_n === 1'b0) cmask[j] = 1'b1;
      if (r2_rd_n === 1'b0) rmask[j] = 1'b1;
      if (r2_done === 1'b1 && done_at2 < 0) done_at2 = j;
    end
    check("p2_done_at_14", done_at2, 14);
    check("p2_wr_low_mask", wmask, 32'h0000_030C);
    check("p2_cs_low_mask", cmask, 32'h0000_0FFF);
    check("p2_rd_low_mask", rmask, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus-cycle generator for the RTC's multiplexed address/data port. It sits directly downstream of the RTC initialisation and read-sequencing logic. It accepts single-transaction read/write requests (register address plus write data) and converts each one into a timed, glitch-free address phase followed by a data phase on the chip's cs_n / ad_n / wr_n / rd_n strobes and 8-bit AD bus. It returns read data and a one-cycle completion pulse.

## Interface
- PHASE_CYC, 10: clk cycles per bus phase (10 × 10 ns = 100 ns at 100 MHz); legal range 2..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_wr  in  1  write request; sampled only in IDLE.
- req_rd  in  1  read request; sampled only in IDLE.
- dir  in  8  RTC register address; latched at accept.
- wdata  in  8  write data; latched at accept.
- ad_in  in  8  AD bus input from the top-level tristate buffer.
- ad_out  out  8  AD bus drive value.
- ad_oe  out  1  AD bus output enable (1 = block drives the bus).
- cs_n  out  1  chip select, active low.
- ad_n  out  1  address/data select (0 = address phase, 1 = data phase).
- wr_n  out  1  write strobe, active low.
- rd_n  out  1  read strobe, active low.
- rdata  out  8  last read value; holds until the next read completes.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at the end of each transaction.

## Operation
- States: IDLE, A_SET, A_STB, A_HOLD, D_SET, D_STB, D_HOLD, RECOV.
- Every non-IDLE state lasts exactly PHASE_CYC cycles, counted by the phase timer. States advance in the listed order. RECOV then returns to IDLE.
- IDLE accepts on req_wr | req_rd. If both are high, the write wins. Accept latches dir, wdata and the op type. Requests seen while busy are ignored, not queued.
- Strobe assignment per state (all outputs registered, no combinational glitches):
  - A_SET and A_HOLD: cs_n=0, ad_n=0, ad_oe=1, ad_out=latched dir.
  - A_STB: the same as A_SET, plus wr_n=0.
  - D_SET and D_HOLD: cs_n=0, ad_n=1.
  - D_STB, write: wr_n=0.
  - D_STB, read: rd_n=0.
  - Data states, write: ad_oe=1, ad_out=latched wdata.
  - Data states, read: ad_oe=0.
  - RECOV: cs_n=1, ad_n=1, wr_n=1, rd_n=1, ad_oe=0.
- Read capture: rdata <= ad_in on the clock edge that ends D_STB, while rd_n is still low. Writes never modify rdata.
- ad_out holds its last value when ad_oe=0.

## Timing
- Reset values: cs_n=1, ad_n=1, wr_n=1, rd_n=1, ad_oe=0, ad_out=0, rdata=0, busy=0, done=0; state=IDLE.
- Reset asserted mid-transaction deasserts all strobes and ad_oe immediately (asynchronously). No done pulse is produced. The aborted transaction is not resumed.
- Accept at edge t. busy=1 from t. done=1 and busy=0 together at edge t + 7·PHASE_CYC. done lasts exactly one cycle.
- The earliest next accept is the edge after done. Back-to-back requests therefore see one idle cycle between transactions.
- Strobe widths are exactly PHASE_CYC cycles. Setup and hold around each strobe are PHASE_CYC cycles each.
- ad_oe never changes in the same cycle a strobe falls or rises: strobe edges occur only at STB entry and exit, and ad_oe changes only at A_SET, D_SET and RECOV entry.
- Phase counter width is $clog2(PHASE_CYC). It wraps to 0 at each state change and never free-runs in IDLE.

## Structure
- Shared package rtc_pkg holds:
  - the bus_state_t enum (8 states);
  - the default PHASE_CYC constant;
  - the RTC register address constants used by upstream sequencers.
- One sub-module, rtc_phase_timer: load/clear on state change, asserts last when count == PHASE_CYC-1.
- The AD tristate buffer lives in the top level, not in this block.

## Test plan
- Reset, then idle: all outputs at their reset values; no strobe activity for 100 cycles.
- Write: dir=0x02, wdata=0x45, req_wr pulse.
  - ad_out=0x02 with ad_n=0 across A_SET..A_HOLD; wr_n low exactly 10 cycles.
  - Then ad_out=0x45 with ad_n=1, wr_n low 10 cycles.
  - done at accept+70; rdata unchanged.
- Read: dir=0x21, bench drives ad_in=0x37 during D_STB.
  - rd_n low 10 cycles with ad_oe=0 throughout the data phase.
  - rdata=0x37 when done pulses.
- req_wr and req_rd together → write performed. A req_rd pulse at accept+20 → ignored; exactly one done.
- reset asserted in D_STB → cs_n, wr_n, rd_n=1 and ad_oe=0 within the same cycle; no done. A new request after reset release completes normally.
- PHASE_CYC=2 → full write transaction in 14 cycles; each strobe exactly 2 cycles.
